// File: rtl/ame_linear_solver_n.sv
// ---------------------------------------------------------------------------
// ame_linear_solver_n
//
// Gauss-Jordan solver for A*X = B on an N x N integer system, used by the
// affine motion estimation path. Partial pivoting, fraction-free elimination
// (R_i <= R_i*m - R_p*A[i][col]), per-row magnitude normalisation after each
// column, and one shared restoring divider that yields signed fixed-point X.
// Any active sub-size n = MAT_N - offs (1..MAT_N) is supported.
//
// Optional build macro: AME_SOLVER_ROUND_EN
//   defined   -> quotient rounds to nearest, ties away from zero
//   undefined -> quotient truncates toward zero
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   comp_init_i  start pulse, sampled only while idle
//   comp_offs_i  first active row/column index
//   comp_data_i  augmented matrix, element [r][c] at bit (r*(MAT_N+1)+c)*DATA_BITS;
//                column MAT_N holds B
//   comp_busy_o  high from accepted start until the done pulse
//   comp_done_o  one-cycle completion pulse
//   comp_err_o   singular system or invalid offset, held until next start
//   comp_data_o  X[c] at bit c*DATA_BITS, signed fixed-point with FRAC_BITS
// ---------------------------------------------------------------------------
module ame_linear_solver_n #(
    parameter int MAT_N     = 6,
    parameter int DATA_BITS = 64,
    parameter int FRAC_BITS = 4,
    parameter int IDX_BITS  = 3
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 comp_init_i,
    input  logic [IDX_BITS-1:0]                  comp_offs_i,
    input  logic [MAT_N*(MAT_N+1)*DATA_BITS-1:0] comp_data_i,
    output logic                                 comp_busy_o,
    output logic                                 comp_done_o,
    output logic                                 comp_err_o,
    output logic [MAT_N*DATA_BITS-1:0]           comp_data_o
);

    localparam int NCOL      = MAT_N + 1;
    localparam int NORM_BITS = DATA_BITS / 2 - 1;
    localparam int SH_BITS   = $clog2(DATA_BITS + 1);
    localparam int CNT_BITS  = $clog2(DATA_BITS);

    typedef logic signed [DATA_BITS-1:0] elem_t;
    typedef logic        [DATA_BITS-1:0] mag_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_PIVOT,
        S_ELIM,
        S_NORM,
        S_DIV_SETUP,
        S_DIV_ITER,
        S_DIV_WR,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    elem_t               mat_reg    [MAT_N][NCOL];
    elem_t               x_reg      [MAT_N];
    logic [IDX_BITS-1:0] pivrow_reg [MAT_N];
    logic [MAT_N-1:0]    used_reg;
    logic [IDX_BITS-1:0] offs_reg;
    logic [IDX_BITS-1:0] col_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                err_reg;

    // Divider state: remainder, shifting dividend/quotient, divisor magnitude.
    mag_t                rem_reg;
    mag_t                quo_reg;
    mag_t                den_reg;
    logic                neg_reg;
    logic [CNT_BITS-1:0] cnt_reg;

    function automatic mag_t mag_of(input elem_t v);
        return v[DATA_BITS-1] ? mag_t'(-v) : mag_t'(v);
    endfunction

    genvar gi, gj;

    // -----------------------------------------------------------------------
    // Active masks: rows/columns offs..MAT_N-1; the B column is always active.
    // -----------------------------------------------------------------------
    logic [MAT_N-1:0] row_act;
    logic [NCOL-1:0]  col_act;
    logic             offs_bad;
    logic             last_col;

    generate
        for (gi = 0; gi < MAT_N; gi++) begin : g_row_act
            assign row_act[gi] = (offs_reg <= IDX_BITS'(gi));
        end
    endgenerate

    assign col_act  = {1'b1, row_act};
    // Widened compare so MAT_N == 2**IDX_BITS still works.
    assign offs_bad = ({1'b0, offs_reg} >= (IDX_BITS + 1)'(MAT_N));
    assign last_col = (col_reg == IDX_BITS'(MAT_N - 1));

    // -----------------------------------------------------------------------
    // Current column values A[r][col] and their magnitudes.
    // -----------------------------------------------------------------------
    elem_t col_val [MAT_N];
    mag_t  col_mag [MAT_N];

    always_comb begin
        for (int r = 0; r < MAT_N; r++) begin
            col_val[r] = '0;
            for (int c = 0; c < MAT_N; c++) begin
                if (col_reg == IDX_BITS'(c)) begin
                    col_val[r] = mat_reg[r][c];
                end
            end
            col_mag[r] = mag_of(col_val[r]);
        end
    end

    // Pivot search: strict '>' keeps the lowest index on ties, and a zero
    // maximum leaves piv_found low (singular column).
    mag_t                piv_best;
    logic [IDX_BITS-1:0] piv_idx;
    logic                piv_found;

    always_comb begin
        piv_best  = '0;
        piv_idx   = '0;
        piv_found = 1'b0;
        for (int r = 0; r < MAT_N; r++) begin
            if (row_act[r] && !used_reg[r] && (col_mag[r] > piv_best)) begin
                piv_best  = col_mag[r];
                piv_idx   = IDX_BITS'(r);
                piv_found = 1'b1;
            end
        end
    end

    // Pivot row of the current column, used by ELIM, NORM and the divider.
    logic [IDX_BITS-1:0] piv_sel;
    elem_t               piv_m;
    elem_t               piv_row [NCOL];
    logic [MAT_N-1:0]    upd_row;

    always_comb begin
        piv_sel = '0;
        for (int c = 0; c < MAT_N; c++) begin
            if (col_reg == IDX_BITS'(c)) begin
                piv_sel = pivrow_reg[c];
            end
        end
        piv_m = '0;
        for (int c = 0; c < NCOL; c++) begin
            piv_row[c] = '0;
        end
        for (int r = 0; r < MAT_N; r++) begin
            if (piv_sel == IDX_BITS'(r)) begin
                piv_m = col_val[r];
                for (int c = 0; c < NCOL; c++) begin
                    piv_row[c] = mat_reg[r][c];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < MAT_N; gi++) begin : g_upd
            assign upd_row[gi] = row_act[gi] && (piv_sel != IDX_BITS'(gi));
        end
    endgenerate

    // Fraction-free elimination candidates for every element.
    elem_t elim_val [MAT_N][NCOL];

    generate
        for (gi = 0; gi < MAT_N; gi++) begin : g_elim_r
            for (gj = 0; gj < NCOL; gj++) begin : g_elim_c
                assign elim_val[gi][gj] = mat_reg[gi][gj] * piv_m - piv_row[gj] * col_val[gi];
            end
        end
    endgenerate

    // Normalisation shift per row. OR-ing the magnitudes gives the same bit
    // length as the maximum magnitude, without a comparator tree.
    mag_t               or_mag  [MAT_N];
    logic [SH_BITS-1:0] bit_len [MAT_N];
    logic [SH_BITS-1:0] norm_sh [MAT_N];

    always_comb begin
        for (int r = 0; r < MAT_N; r++) begin
            or_mag[r] = '0;
            for (int c = 0; c < NCOL; c++) begin
                if (col_act[c]) begin
                    or_mag[r] = or_mag[r] | mag_of(mat_reg[r][c]);
                end
            end
            bit_len[r] = '0;
            for (int b = 0; b < DATA_BITS; b++) begin
                if (or_mag[r][b]) begin
                    bit_len[r] = SH_BITS'(b + 1);
                end
            end
            norm_sh[r] = (bit_len[r] > SH_BITS'(NORM_BITS)) ?
                         (bit_len[r] - SH_BITS'(NORM_BITS)) : '0;
        end
    end

    // Divider operands for the current unknown.
    mag_t div_num;
    mag_t div_den;

    always_comb begin
        div_den = mag_of(piv_m);
        div_num = mag_of(piv_row[MAT_N]) << FRAC_BITS;
`ifdef AME_SOLVER_ROUND_EN
        // Half the divisor added up front turns truncation into
        // round-half-away-from-zero on the magnitude.
        div_num = div_num + (div_den >> 1);
`endif
    end

    logic [DATA_BITS:0] rem_shift;
    logic               rem_ge;

    assign rem_shift = {rem_reg, quo_reg[DATA_BITS-1]};
    assign rem_ge    = (rem_shift >= {1'b0, den_reg});

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (comp_init_i) state_next = S_LOAD;
            S_LOAD:      state_next = offs_bad ? S_DONE : S_PIVOT;
            S_PIVOT:     state_next = piv_found ? S_ELIM : S_DONE;
            S_ELIM:      state_next = S_NORM;
            S_NORM:      state_next = last_col ? S_DIV_SETUP : S_PIVOT;
            S_DIV_SETUP: state_next = S_DIV_ITER;
            S_DIV_ITER:  if (cnt_reg == CNT_BITS'(DATA_BITS - 1)) state_next = S_DIV_WR;
            S_DIV_WR:    state_next = last_col ? S_DONE : S_DIV_SETUP;
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < MAT_N; r++) begin
                for (int c = 0; c < NCOL; c++) begin
                    mat_reg[r][c] <= '0;
                end
                x_reg[r]      <= '0;
                pivrow_reg[r] <= '0;
            end
            used_reg <= '0;
            offs_reg <= '0;
            col_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            rem_reg  <= '0;
            quo_reg  <= '0;
            den_reg  <= '0;
            neg_reg  <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (comp_init_i) begin
                        for (int r = 0; r < MAT_N; r++) begin
                            for (int c = 0; c < NCOL; c++) begin
                                mat_reg[r][c] <= comp_data_i[(r*NCOL + c)*DATA_BITS +: DATA_BITS];
                            end
                            x_reg[r] <= '0;
                        end
                        offs_reg <= comp_offs_i;
                        err_reg  <= 1'b0;
                        busy_reg <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (offs_bad) begin
                        err_reg <= 1'b1;
                    end else begin
                        col_reg  <= offs_reg;
                        used_reg <= '0;
                    end
                end
                S_PIVOT: begin
                    if (!piv_found) begin
                        err_reg <= 1'b1;
                    end else begin
                        used_reg[piv_idx] <= 1'b1;
                        for (int c = 0; c < MAT_N; c++) begin
                            if (col_reg == IDX_BITS'(c)) begin
                                pivrow_reg[c] <= piv_idx;
                            end
                        end
                    end
                end
                S_ELIM: begin
                    for (int r = 0; r < MAT_N; r++) begin
                        for (int c = 0; c < NCOL; c++) begin
                            if (upd_row[r] && col_act[c]) begin
                                mat_reg[r][c] <= elim_val[r][c];
                            end
                        end
                    end
                end
                S_NORM: begin
                    for (int r = 0; r < MAT_N; r++) begin
                        for (int c = 0; c < NCOL; c++) begin
                            if (upd_row[r] && col_act[c]) begin
                                mat_reg[r][c] <= mat_reg[r][c] >>> norm_sh[r];
                            end
                        end
                    end
                    col_reg <= last_col ? offs_reg : (col_reg + IDX_BITS'(1));
                end
                S_DIV_SETUP: begin
                    quo_reg <= div_num;
                    rem_reg <= '0;
                    den_reg <= div_den;
                    neg_reg <= piv_row[MAT_N][DATA_BITS-1] ^ piv_m[DATA_BITS-1];
                    cnt_reg <= '0;
                end
                S_DIV_ITER: begin
                    // Restoring step: the remainder stays below the divisor,
                    // so it always fits back into DATA_BITS.
                    rem_reg <= rem_ge ? DATA_BITS'(rem_shift - {1'b0, den_reg})
                                      : rem_shift[DATA_BITS-1:0];
                    quo_reg <= {quo_reg[DATA_BITS-2:0], rem_ge};
                    cnt_reg <= cnt_reg + CNT_BITS'(1);
                end
                S_DIV_WR: begin
                    for (int c = 0; c < MAT_N; c++) begin
                        if (col_reg == IDX_BITS'(c)) begin
                            x_reg[c] <= neg_reg ? elem_t'(-quo_reg) : elem_t'(quo_reg);
                        end
                    end
                    if (!last_col) begin
                        col_reg <= col_reg + IDX_BITS'(1);
                    end
                end
                S_DONE: begin
                    done_reg <= 1'b1;
                    busy_reg <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign comp_busy_o = busy_reg;
    assign comp_done_o = done_reg;
    assign comp_err_o  = err_reg;

    generate
        for (gi = 0; gi < MAT_N; gi++) begin : g_out
            assign comp_data_o[gi*DATA_BITS +: DATA_BITS] = x_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_ame_linear_solver_n.sv
// ---------------------------------------------------------------------------
// Directed testbench for ame_linear_solver_n with hand-computed expectations.
// Honours AME_SOLVER_ROUND_EN for the rounding vectors.
// ---------------------------------------------------------------------------
module tb_ame_linear_solver_n;

    localparam int N  = 6;
    localparam int DB = 64;
    localparam int FB = 4;
    localparam int IB = 3;

    logic                    clk_i       = 1'b0;
    logic                    rst_i       = 1'b0;
    logic                    comp_init_i = 1'b0;
    logic [IB-1:0]           comp_offs_i = '0;
    logic [N*(N+1)*DB-1:0]   comp_data_i = '0;
    logic                    comp_busy_o;
    logic                    comp_done_o;
    logic                    comp_err_o;
    logic [N*DB-1:0]         comp_data_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic signed [DB-1:0] mat [N][N+1];

    always #5 clk_i = ~clk_i;

    ame_linear_solver_n #(
        .MAT_N     (N),
        .DATA_BITS (DB),
        .FRAC_BITS (FB),
        .IDX_BITS  (IB)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .comp_init_i (comp_init_i),
        .comp_offs_i (comp_offs_i),
        .comp_data_i (comp_data_i),
        .comp_busy_o (comp_busy_o),
        .comp_done_o (comp_done_o),
        .comp_err_o  (comp_err_o),
        .comp_data_o (comp_data_o)
    );

    task automatic chk(input string tag, input logic signed [DB-1:0] obs,
                       input logic signed [DB-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [DB-1:0] xo(input int i);
        return comp_data_o[i*DB +: DB];
    endfunction

    task automatic fill(input logic signed [DB-1:0] v);
        for (int r = 0; r < N; r++)
            for (int c = 0; c <= N; c++)
                mat[r][c] = v;
    endtask

    task automatic pack();
        for (int r = 0; r < N; r++)
            for (int c = 0; c <= N; c++)
                comp_data_i[(r*(N+1)+c)*DB +: DB] = mat[r][c];
    endtask

    // Starts a solve and returns the number of edges from the init-sample
    // edge to the cycle in which done is seen.
    task automatic run(input string tag, input logic [IB-1:0] offs, output int lat);
        pack();
        comp_offs_i = offs;
        comp_init_i = 1'b1;
        @(posedge clk_i); #1;
        comp_init_i = 1'b0;
        chk({tag, "_busy_up"}, comp_busy_o, 1);
        chk({tag, "_x_cleared"}, (comp_data_o == '0), 1);
        lat = 0;
        while (comp_done_o !== 1'b1 && lat < 3000) begin
            @(posedge clk_i); #1;
            lat++;
        end
        chk({tag, "_busy_drop"}, comp_busy_o, 0);
        @(posedge clk_i); #1;
        chk({tag, "_done_pulse"}, comp_done_o, 0);
    endtask

    int lat;
    int dones;
    logic signed [DB-1:0] exp_pos;
    logic signed [DB-1:0] exp_neg;

    initial begin
`ifdef AME_SOLVER_ROUND_EN
        exp_pos = 11;
        exp_neg = -11;
`else
        exp_pos = 10;
        exp_neg = -10;
`endif
        // Reset
        #1 rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_busy", comp_busy_o, 0);
        chk("rst_done", comp_done_o, 0);
        chk("rst_err", comp_err_o, 0);
        chk("rst_data", (comp_data_o == '0), 1);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // 1: full 6x6, A = 2I
        fill(0);
        for (int i = 0; i < N; i++) begin
            mat[i][i] = 2;
            mat[i][N] = 2 * (i + 1);
        end
        run("t1", 3'd0, lat);
        chk("t1_lat", lat, 416);
        chk("t1_err", comp_err_o, 0);
        for (int i = 0; i < N; i++) chk($sformatf("t1_x%0d", i), xo(i), 16 * (i + 1));

        // 2: 4x4 at offs 2, A = 4I, inactive entries are garbage
        fill(77);
        for (int r = 2; r < N; r++) begin
            for (int c = 2; c < N; c++) mat[r][c] = (r == c) ? 4 : 0;
            mat[r][N] = r - 1;
        end
        run("t2", 3'd2, lat);
        chk("t2_lat", lat, 278);
        chk("t2_err", comp_err_o, 0);
        chk("t2_x0", xo(0), 0);
        chk("t2_x1", xo(1), 0);
        for (int i = 2; i < N; i++) chk($sformatf("t2_x%0d", i), xo(i), 4 * (i - 1));

        // 3: 2x2 pivot swap
        fill(0);
        mat[4][5] = 1; mat[4][6] = 3;
        mat[5][4] = 1; mat[5][6] = 5;
        run("t3", 3'd4, lat);
        chk("t3_lat", lat, 140);
        chk("t3_x4", xo(4), 80);
        chk("t3_x5", xo(5), 48);

        // 4: 1x1 rounding/truncation, both signs
        fill(0);
        mat[5][5] = 3; mat[5][6] = 2;
        run("t4a", 3'd5, lat);
        chk("t4a_lat", lat, 71);
        chk("t4a_x5", xo(5), exp_pos);
        chk("t4a_x4", xo(4), 0);
        mat[5][5] = -3;
        run("t4b", 3'd5, lat);
        chk("t4b_x5", xo(5), exp_neg);

        // 5: singular column 0, then invalid offset
        fill(0);
        for (int i = 1; i < N; i++) mat[i][i] = 1;
        mat[0][N] = 9;
        run("t5a", 3'd0, lat);
        chk("t5a_lat", lat, 3);
        chk("t5a_err", comp_err_o, 1);
        chk("t5a_data", (comp_data_o == '0), 1);
        run("t5b", 3'd6, lat);
        chk("t5b_lat", lat, 2);
        chk("t5b_err", comp_err_o, 1);

        // Singular second column (rows dependent after elimination)
        fill(0);
        mat[4][4] = 1; mat[4][5] = 2; mat[4][6] = 1;
        mat[5][4] = 2; mat[5][5] = 4; mat[5][6] = 1;
        run("t5c", 3'd4, lat);
        chk("t5c_lat", lat, 6);
        chk("t5c_err", comp_err_o, 1);

        // General 2x2: [[2,1],[1,3]] X = [5,10] -> X = [1,3]
        fill(0);
        mat[4][4] = 2; mat[4][5] = 1; mat[4][6] = 5;
        mat[5][4] = 1; mat[5][5] = 3; mat[5][6] = 10;
        run("t7", 3'd4, lat);
        chk("t7_err", comp_err_o, 0);
        chk("t7_x4", xo(4), 16);
        chk("t7_x5", xo(5), 48);

        // 6a: reset during DIV
        fill(0);
        for (int i = 0; i < N; i++) begin
            mat[i][i] = 2;
            mat[i][N] = 2 * (i + 1);
        end
        pack();
        comp_offs_i = 3'd0;
        comp_init_i = 1'b1;
        @(posedge clk_i); #1;
        comp_init_i = 1'b0;
        repeat (100) @(posedge clk_i);
        #2;
        chk("t6_pre_x0", xo(0), 16);
        chk("t6_pre_busy", comp_busy_o, 1);
        rst_i = 1'b1;
        #1;
        chk("t6_rst_busy", comp_busy_o, 0);
        chk("t6_rst_data", (comp_data_o == '0), 1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        dones = 0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk_i); #1;
            if (comp_done_o === 1'b1) dones++;
        end
        chk("t6_no_done", dones, 0);
        chk("t6_idle_busy", comp_busy_o, 0);

        // 6b: init while busy is ignored
        fill(77);
        for (int r = 2; r < N; r++) begin
            for (int c = 2; c < N; c++) mat[r][c] = (r == c) ? 4 : 0;
            mat[r][N] = r - 1;
        end
        pack();
        comp_offs_i = 3'd2;
        comp_init_i = 1'b1;
        @(posedge clk_i); #1;
        comp_init_i = 1'b0;
        lat = 0;
        while (comp_done_o !== 1'b1 && lat < 3000) begin
            @(posedge clk_i); #1;
            lat++;
            if (lat == 10) begin
                comp_offs_i = 3'd4;
                comp_init_i = 1'b1;
            end
            if (lat == 11) comp_init_i = 1'b0;
        end
        chk("t6b_lat", lat, 278);
        chk("t6b_x2", xo(2), 4);
        chk("t6b_x5", xo(5), 16);
        @(posedge clk_i); #1;

        // 6c: fresh init after done
        fill(0);
        mat[4][5] = 1; mat[4][6] = 3;
        mat[5][4] = 1; mat[5][6] = 5;
        run("t6c", 3'd4, lat);
        chk("t6c_lat", lat, 140);
        chk("t6c_x4", xo(4), 80);
        chk("t6c_x5", xo(5), 48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ame_linear_solver_n.md
Name: ame_linear_solver_n

Overview:
Parametrised Gauss-Jordan solver for the affine motion estimation (AME) path. It solves an N x N integer system A*X = B with partial pivoting, fraction-free elimination, per-row magnitude normalisation and a shared sequential divider. It produces signed fixed-point X for any active sub-size from 1 up to MAT_N, so 4-parameter and 6-parameter affine models, and larger, use one instance. It also reports singular systems explicitly.

Parameters:
MAT_N, 6, maximum system dimension; the augmented matrix is MAT_N x (MAT_N+1).
DATA_BITS, 64, signed element and result width.
FRAC_BITS, 4, fractional bits of results.
IDX_BITS, 3, row/column index width; must satisfy 2^IDX_BITS >= MAT_N.

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  asynchronous active-high reset
comp_init_i  in  1  start pulse; sampled only in IDLE
comp_offs_i  in  IDX_BITS  first active index; active rows/columns are offs..MAT_N-1, so n = MAT_N-offs
comp_data_i  in  MAT_N*(MAT_N+1)*DATA_BITS  [row][col] signed; col MAT_N is B
comp_busy_o  out  1  high from accepted init until done pulse
comp_done_o  out  1  one-cycle completion pulse
comp_err_o  out  1  singular or invalid offset; valid with done, held until next accepted init
comp_data_o  out  MAT_N*DATA_BITS  X[col], signed fixed-point; held until next accepted init

Behaviour:
- Reset values: all outputs 0; state IDLE; matrix, masks and divider registers cleared. Reset mid-solve aborts immediately. No done pulse follows the abort.
- Inputs: active A/B magnitudes must fit in DATA_BITS/2-1 signed bits. Inactive entries are ignored.
- States:
  - IDLE: on comp_init_i, capture comp_data_i and comp_offs_i, clear comp_data_o and comp_err_o, go to LOAD.
  - LOAD (1 cycle): if offs >= MAT_N, set err and go to DONE. Otherwise set col=offs, clear the used-row mask and go to PIVOT.
  - PIVOT (1 cycle): select the unused active row with the largest |A[r][col]|; the lowest index wins ties. If the maximum is 0, set err and go to DONE. Otherwise mark the row used, record pivrow[col] and go to ELIM.
  - ELIM (1 cycle): with m = A[p][col], for every active row i != p, compute R_i <= R_i*m - R_p*A[i][col] over the active columns and B, in full DATA_BITS signed arithmetic. The pivot row is unchanged.
  - NORM (1 cycle): arithmetic-right-shift each updated row by k = max(0, bitlen(max|elem|) - (DATA_BITS/2-1)), where bitlen is the magnitude bit length. Then if col == MAT_N-1, go to DIV with col=offs; otherwise go to PIVOT with col+1.
  - DIV: for each active col in order, compute X[col] = (B[p] << FRAC_BITS) / A[p][col] with p = pivrow[col]. Uses a restoring divider on magnitudes, one quotient bit per cycle: 1 setup cycle + DATA_BITS iterations + 1 sign/write cycle = DATA_BITS+2 cycles per unknown. Quotient truncates toward zero. After the last unknown, go to DONE.
  - DONE (1 cycle): comp_done_o=1, busy drops, then IDLE.
- Latency, init-sample edge to done-pulse cycle: 2 + 3n + n*(DATA_BITS+2) cycles. With defaults: n=6 gives 416 cycles, n=4 gives 278 cycles. A singular column j (zero-based within the active set) gives done at 3 + 3j.
- Inactive X entries, and all X entries on error, read 0.
- comp_init_i while busy is ignored; there is no queueing.
- Init and done in the same cycle cannot occur, because init is sampled only in IDLE.

Optional Feature:
Macro AME_SOLVER_ROUND_EN.
- Defined: the divider rounds to nearest, ties away from zero. This is done by adding |divisor|>>1 to the dividend magnitude before the iterations; timing is unchanged.
- Undefined: quotient truncates toward zero.

Test Plan:
1. offs=0, A=2*I, B=[2,4,6,8,10,12] -> X=[16,32,48,64,80,96], err=0, done exactly 416 cycles after init.
2. offs=2, A=4*I (4x4), B=[1,2,3,4] -> X[2..5]=[4,8,12,16], X[0..1]=0, done at 278 cycles.
3. offs=4, A=[[0,1],[1,0]], B=[3,5] -> pivot swap exercised; X[4]=80, X[5]=48.
4. offs=5, A=3, B=2 -> X[5]=10 (truncate) or 11 (AME_SOLVER_ROUND_EN); A=-3, B=2 -> -10 or -11.
5. offs=0, column 0 all zero -> done 3 cycles after init, err=1, all X=0. Then offs=6 -> err=1 via LOAD.
6. Assert rst_i mid-DIV -> outputs 0 and no done pulse. comp_init_i pulsed while busy -> ignored; a fresh init after done solves correctly.
